lsu: RTL and testbench



---
 rtl/lsu_pkg.sv | 35 +++
 rtl/lsu_if.sv | 32 +++
 rtl/lsu_align.sv | 83 ++++++++
 rtl/lsu.sv | 203 ++++++++++++++++++++
 tb/tb_lsu.sv | 347 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: funct3 access codes, AXI response
// codes, FSM state encoding and load extension helpers.
package lsu_pkg;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_AR   = 3'd1,
    S_R    = 3'd2,
    S_W    = 3'd3,
    S_B    = 3'd4,
    S_DONE = 3'd5
  } lsu_state_e;

  function automatic logic [31:0] ext8(input logic [7:0] b, input logic sgn);
    return {{24{sgn & b[7]}}, b};
  endfunction

  function automatic logic [31:0] ext16(input logic [15:0] h, input logic sgn);
    return {{16{sgn & h[15]}}, h};
  endfunction

endpackage

// File: rtl/lsu_if.sv
// AXI4-Lite bus between the LSU (master) and the memory system (slave).
interface lsu_if;

  logic [31:0] araddr;
  logic        arvalid;
  logic        arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid;
  logic        rready;
  logic [31:0] awaddr;
  logic        awvalid;
  logic        awready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wvalid;
  logic        wready;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready;

  modport master (
    output araddr, arvalid, rready, awaddr, awvalid, wdata, wstrb, wvalid, bready,
    input  arready, rdata, rresp, rvalid, awready, wready, bresp, bvalid
  );

  modport slave (
    input  araddr, arvalid, rready, awaddr, awvalid, wdata, wstrb, wvalid, bready,
    output arready, rdata, rresp, rvalid, awready, wready, bresp, bvalid
  );

endinterface

// File: rtl/lsu_align.sv
// Combinational lane logic: store strobe/data placement, load extraction and
// extension, and the misalignment check (enabled by LSU_MISALIGN_CHK_EN).
module lsu_align
  import lsu_pkg::*;
(
  input  logic [1:0]  off,
  input  logic [2:0]  funct3,
  input  logic [31:0] st_data,
  input  logic [31:0] ld_raw,
  output logic [31:0] st_wdata,
  output logic [3:0]  st_wstrb,
  output logic [31:0] ld_data,
  output logic        misalign
);

  logic [4:0]  sh_amt_s;
  logic [7:0]  ld_byte_s;
  logic [15:0] ld_half_s;

  assign sh_amt_s = {off, 3'b000};

  // Store placement: lanes shifted past bit 31 simply fall off
  always_comb begin
    st_wdata = st_data;
    st_wstrb = 4'b1111;
    case (funct3)
      F3_SB: begin
        st_wdata = st_data << sh_amt_s;
        st_wstrb = 4'b0001 << off;
      end
      F3_SH: begin
        st_wdata = st_data << sh_amt_s;
        st_wstrb = 4'b0011 << off;
      end
      F3_SW: begin
        st_wdata = st_data;
        st_wstrb = 4'b1111;
      end
      default: begin
        st_wdata = st_data;
        st_wstrb = 4'b1111;
      end
    endcase
  end

  // Byte and halfword selection from the returned word
  always_comb begin
    ld_byte_s = ld_raw[7:0];
    case (off)
      2'd0:    ld_byte_s = ld_raw[7:0];
      2'd1:    ld_byte_s = ld_raw[15:8];
      2'd2:    ld_byte_s = ld_raw[23:16];
      2'd3:    ld_byte_s = ld_raw[31:24];
      default: ld_byte_s = ld_raw[7:0];
    endcase
    if (off[1]) begin
      ld_half_s = ld_raw[31:16];
    end else begin
      ld_half_s = ld_raw[15:0];
    end
  end

  // Sign or zero extension by access type
  always_comb begin
    ld_data = ld_raw;
    case (funct3)
      F3_LB:   ld_data = ext8(ld_byte_s, 1'b1);
      F3_LBU:  ld_data = ext8(ld_byte_s, 1'b0);
      F3_LH:   ld_data = ext16(ld_half_s, 1'b1);
      F3_LHU:  ld_data = ext16(ld_half_s, 1'b0);
      F3_LW:   ld_data = ld_raw;
      default: ld_data = ld_raw;
    endcase
  end

`ifdef LSU_MISALIGN_CHK_EN
  assign misalign = ((funct3[1:0] == 2'b01) && off[0]) ||
                    ((funct3[1:0] == 2'b10) && (off != 2'b00));
`else
  assign misalign = 1'b0;
`endif

endmodule

// File: rtl/lsu.sv
// Multi-cycle load/store unit between EXU and WBU; issues at most one AXI4-Lite
// transaction per instruction. Optional misalign trap: LSU_MISALIGN_CHK_EN.
module lsu
  import lsu_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        i_pre_valid,
  output logic        o_pre_ready,
  output logic        o_post_valid,
  input  logic        i_post_ready,
  input  logic [31:0] i_lsu_addr,
  input  logic [31:0] i_lsu_wdata,
  input  logic [31:0] i_lsu_alu_res,
  input  logic        i_lsu_ren,
  input  logic        i_lsu_wen,
  input  logic [2:0]  i_lsu_funct3,
  output logic [31:0] o_lsu_rd,
  output logic        o_lsu_bus_err,
  output logic        o_lsu_misalign,
  lsu_if.master       axi
);

  lsu_state_e  state_r;
  logic [1:0]  off_r;
  logic [2:0]  funct3_r;
  logic        post_valid_r;
  logic [31:0] rd_r;
  logic        bus_err_r;
  logic        misalign_r;
  logic        arvalid_r;
  logic [31:0] araddr_r;
  logic        rready_r;
  logic        awvalid_r;
  logic [31:0] awaddr_r;
  logic        wvalid_r;
  logic [31:0] wdata_r;
  logic [3:0]  wstrb_r;
  logic        bready_r;

  logic [1:0]  off_s;
  logic [2:0]  funct3_s;
  logic [31:0] st_wdata_s;
  logic [3:0]  st_wstrb_s;
  logic [31:0] ld_data_s;
  logic        misalign_s;
  logic        aw_acc_s;
  logic        w_acc_s;

  // Lane logic sees the live EXU request while idle, the latched one afterwards
  always_comb begin
    off_s    = off_r;
    funct3_s = funct3_r;
    if (state_r == S_IDLE) begin
      off_s    = i_lsu_addr[1:0];
      funct3_s = i_lsu_funct3;
    end else begin
      off_s    = off_r;
      funct3_s = funct3_r;
    end
  end

  lsu_align u_align (
    .off      (off_s),
    .funct3   (funct3_s),
    .st_data  (i_lsu_wdata),
    .ld_raw   (axi.rdata),
    .st_wdata (st_wdata_s),
    .st_wstrb (st_wstrb_s),
    .ld_data  (ld_data_s),
    .misalign (misalign_s)
  );

  // A dropped valid in W means that channel was already accepted
  assign aw_acc_s = !awvalid_r || axi.awready;
  assign w_acc_s  = !wvalid_r  || axi.wready;

  // Main FSM with all bus and WBU outputs registered
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r      <= S_IDLE;
      off_r        <= 2'b00;
      funct3_r     <= 3'b000;
      post_valid_r <= 1'b0;
      rd_r         <= 32'h0000_0000;
      bus_err_r    <= 1'b0;
      misalign_r   <= 1'b0;
      arvalid_r    <= 1'b0;
      araddr_r     <= 32'h0000_0000;
      rready_r     <= 1'b0;
      awvalid_r    <= 1'b0;
      awaddr_r     <= 32'h0000_0000;
      wvalid_r     <= 1'b0;
      wdata_r      <= 32'h0000_0000;
      wstrb_r      <= 4'b0000;
      bready_r     <= 1'b0;
    end else begin
      case (state_r)
        S_IDLE: begin
          if (i_pre_valid) begin
            off_r      <= i_lsu_addr[1:0];
            funct3_r   <= i_lsu_funct3;
            bus_err_r  <= 1'b0;
            misalign_r <= 1'b0;
            if ((i_lsu_wen || i_lsu_ren) && misalign_s) begin
              rd_r         <= 32'h0000_0000;
              misalign_r   <= 1'b1;
              post_valid_r <= 1'b1;
              state_r      <= S_DONE;
            end else if (i_lsu_wen) begin
              awaddr_r  <= i_lsu_addr;
              wdata_r   <= st_wdata_s;
              wstrb_r   <= st_wstrb_s;
              awvalid_r <= 1'b1;
              wvalid_r  <= 1'b1;
              state_r   <= S_W;
            end else if (i_lsu_ren) begin
              araddr_r  <= i_lsu_addr;
              arvalid_r <= 1'b1;
              state_r   <= S_AR;
            end else begin
              rd_r         <= i_lsu_alu_res;
              post_valid_r <= 1'b1;
              state_r      <= S_DONE;
            end
          end
        end
        S_AR: begin
          if (axi.arready) begin
            arvalid_r <= 1'b0;
            rready_r  <= 1'b1;
            state_r   <= S_R;
          end
        end
        S_R: begin
          if (axi.rvalid) begin
            rready_r     <= 1'b0;
            rd_r         <= ld_data_s;
            bus_err_r    <= (axi.rresp != RESP_OKAY);
            post_valid_r <= 1'b1;
            state_r      <= S_DONE;
          end
        end
        S_W: begin
          if (aw_acc_s && w_acc_s) begin
            awvalid_r <= 1'b0;
            wvalid_r  <= 1'b0;
            bready_r  <= 1'b1;
            state_r   <= S_B;
          end else begin
            if (awvalid_r && axi.awready) begin
              awvalid_r <= 1'b0;
            end
            if (wvalid_r && axi.wready) begin
              wvalid_r <= 1'b0;
            end
          end
        end
        S_B: begin
          if (axi.bvalid) begin
            bready_r     <= 1'b0;
            rd_r         <= 32'h0000_0000;
            bus_err_r    <= (axi.bresp != RESP_OKAY);
            post_valid_r <= 1'b1;
            state_r      <= S_DONE;
          end
        end
        S_DONE: begin
          if (i_post_ready) begin
            post_valid_r <= 1'b0;
            state_r      <= S_IDLE;
          end
        end
        default: begin
          post_valid_r <= 1'b0;
          arvalid_r    <= 1'b0;
          rready_r     <= 1'b0;
          awvalid_r    <= 1'b0;
          wvalid_r     <= 1'b0;
          bready_r     <= 1'b0;
          state_r      <= S_IDLE;
        end
      endcase
    end
  end

  assign o_pre_ready    = (state_r == S_IDLE);
  assign o_post_valid   = post_valid_r;
  assign o_lsu_rd       = rd_r;
  assign o_lsu_bus_err  = bus_err_r;
  assign o_lsu_misalign = misalign_r;

  assign axi.araddr  = araddr_r;
  assign axi.arvalid = arvalid_r;
  assign axi.rready  = rready_r;
  assign axi.awaddr  = awaddr_r;
  assign axi.awvalid = awvalid_r;
  assign axi.wdata   = wdata_r;
  assign axi.wstrb   = wstrb_r;
  assign axi.wvalid  = wvalid_r;
  assign axi.bready  = bready_r;

endmodule

// File: tb/tb_lsu.sv
// Self-checking bench for lsu: a wait-state-configurable AXI4-Lite slave plus a
// queue of expected write-back results checked as each instruction completes.
module tb_lsu;
  import lsu_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        i_pre_valid = 1'b0;
  logic        i_post_ready = 1'b0;
  logic [31:0] i_lsu_addr = 32'h0;
  logic [31:0] i_lsu_wdata = 32'h0;
  logic [31:0] i_lsu_alu_res = 32'h0;
  logic        i_lsu_ren = 1'b0;
  logic        i_lsu_wen = 1'b0;
  logic [2:0]  i_lsu_funct3 = 3'b000;
  logic        o_pre_ready;
  logic        o_post_valid;
  logic [31:0] o_lsu_rd;
  logic        o_lsu_bus_err;
  logic        o_lsu_misalign;

  lsu_if bus ();

  lsu dut (
    .clk            (clk),
    .rst            (rst),
    .i_pre_valid    (i_pre_valid),
    .o_pre_ready    (o_pre_ready),
    .o_post_valid   (o_post_valid),
    .i_post_ready   (i_post_ready),
    .i_lsu_addr     (i_lsu_addr),
    .i_lsu_wdata    (i_lsu_wdata),
    .i_lsu_alu_res  (i_lsu_alu_res),
    .i_lsu_ren      (i_lsu_ren),
    .i_lsu_wen      (i_lsu_wen),
    .i_lsu_funct3   (i_lsu_funct3),
    .o_lsu_rd       (o_lsu_rd),
    .o_lsu_bus_err  (o_lsu_bus_err),
    .o_lsu_misalign (o_lsu_misalign),
    .axi            (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [31:0] rd;
    logic        err;
    logic        mis;
  } exp_t;
  exp_t sb_q[$];

  // slave configuration, written by the stimulus process
  int          ar_wait = 0, r_wait = 0, aw_wait = 0, w_wait = 0, b_wait = 0;
  logic [31:0] cfg_rdata = 32'h0;
  logic [1:0]  cfg_rresp = 2'b00;
  logic [1:0]  cfg_bresp = 2'b00;

  // slave state and observations, written only by the slave process
  int          ar_cnt = 0, r_cnt = 0, aw_cnt = 0, w_cnt = 0, b_cnt = 0;
  int          ar_seen = 0, aw_seen = 0, w_seen = 0;
  logic [31:0] last_araddr = 32'h0, last_awaddr = 32'h0, last_wdata = 32'h0;
  logic [3:0]  last_wstrb = 4'h0;

  // AXI slave: each channel answers after its configured number of wait cycles
  always @(negedge clk) begin
    if (bus.arvalid) begin
      ar_seen++;
      last_araddr = bus.araddr;
      if (ar_cnt >= ar_wait) bus.arready = 1'b1;
      else begin bus.arready = 1'b0; ar_cnt++; end
    end else begin bus.arready = 1'b0; ar_cnt = 0; end
    if (bus.rready) begin
      if (r_cnt >= r_wait) begin
        bus.rvalid = 1'b1; bus.rdata = cfg_rdata; bus.rresp = cfg_rresp;
      end else begin bus.rvalid = 1'b0; r_cnt++; end
    end else begin bus.rvalid = 1'b0; bus.rdata = 32'h0; bus.rresp = 2'b00; r_cnt = 0; end
    if (bus.awvalid) begin
      aw_seen++;
      last_awaddr = bus.awaddr;
      if (aw_cnt >= aw_wait) bus.awready = 1'b1;
      else begin bus.awready = 1'b0; aw_cnt++; end
    end else begin bus.awready = 1'b0; aw_cnt = 0; end
    if (bus.wvalid) begin
      w_seen++;
      last_wdata = bus.wdata;
      last_wstrb = bus.wstrb;
      if (w_cnt >= w_wait) bus.wready = 1'b1;
      else begin bus.wready = 1'b0; w_cnt++; end
    end else begin bus.wready = 1'b0; w_cnt = 0; end
    if (bus.bready) begin
      if (b_cnt >= b_wait) begin bus.bvalid = 1'b1; bus.bresp = cfg_bresp; end
      else begin bus.bvalid = 1'b0; b_cnt++; end
    end else begin bus.bvalid = 1'b0; bus.bresp = 2'b00; b_cnt = 0; end
  end

  task automatic run_op(input string name, input logic ren, input logic wen,
                        input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [31:0] alu,
                        input logic [31:0] exp_rd, input logic exp_err,
                        input logic exp_mis, input int exp_lat, input int hold);
    exp_t e;
    int   lat;
    @(negedge clk);
    checks++;
    if (o_pre_ready !== 1'b1) begin
      errors++; $display("FAIL %s pre_ready_idle: got %b want 1", name, o_pre_ready);
    end
    i_lsu_ren = ren; i_lsu_wen = wen; i_lsu_funct3 = f3;
    i_lsu_addr = addr; i_lsu_wdata = wdata; i_lsu_alu_res = alu;
    i_pre_valid = 1'b1;
    sb_q.push_back('{rd: exp_rd, err: exp_err, mis: exp_mis});
    @(negedge clk);
    i_pre_valid = 1'b0; i_lsu_ren = 1'b0; i_lsu_wen = 1'b0;
    i_lsu_addr = 32'h0; i_lsu_wdata = 32'h0; i_lsu_alu_res = 32'h0;
    checks++;
    if (o_pre_ready !== 1'b0) begin
      errors++; $display("FAIL %s pre_ready_busy: got %b want 0", name, o_pre_ready);
    end
    lat = 1;
    while (o_post_valid !== 1'b1 && lat < 50) begin
      @(negedge clk);
      lat++;
    end
    checks++;
    if (o_post_valid !== 1'b1) begin
      errors++; $display("FAIL %s timeout: no post_valid after %0d cycles", name, lat);
      void'(sb_q.pop_front());
    end else begin
      checks++;
      if (lat != exp_lat) begin
        errors++; $display("FAIL %s latency: got T+%0d want T+%0d", name, lat, exp_lat);
      end
      e = sb_q.pop_front();
      checks++;
      if (o_lsu_rd !== e.rd) begin
        errors++; $display("FAIL %s rd: got %h want %h", name, o_lsu_rd, e.rd);
      end
      checks++;
      if (o_lsu_bus_err !== e.err) begin
        errors++; $display("FAIL %s bus_err: got %b want %b", name, o_lsu_bus_err, e.err);
      end
      checks++;
      if (o_lsu_misalign !== e.mis) begin
        errors++; $display("FAIL %s misalign: got %b want %b", name, o_lsu_misalign, e.mis);
      end
      for (int i = 0; i < hold; i++) begin
        @(negedge clk);
        checks++;
        if (o_post_valid !== 1'b1 || o_lsu_rd !== e.rd || o_lsu_bus_err !== e.err) begin
          errors++;
          $display("FAIL %s hold%0d: got v=%b rd=%h err=%b want v=1 rd=%h err=%b",
                   name, i, o_post_valid, o_lsu_rd, o_lsu_bus_err, e.rd, e.err);
        end
      end
    end
    i_post_ready = 1'b1;
    @(negedge clk);
    i_post_ready = 1'b0;
    checks++;
    if (o_post_valid !== 1'b0 || o_pre_ready !== 1'b1) begin
      errors++;
      $display("FAIL %s release: got v=%b pre_ready=%b want v=0 pre_ready=1",
               name, o_post_valid, o_pre_ready);
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (o_pre_ready !== 1'b1 || o_post_valid !== 1'b0 || o_lsu_rd !== 32'h0 ||
        o_lsu_bus_err !== 1'b0 || o_lsu_misalign !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs: got pre=%b v=%b rd=%h err=%b mis=%b want 1 0 0 0 0",
               o_pre_ready, o_post_valid, o_lsu_rd, o_lsu_bus_err, o_lsu_misalign);
    end
    checks++;
    if ({bus.arvalid, bus.rready, bus.awvalid, bus.wvalid, bus.bready} !== 5'b00000) begin
      errors++;
      $display("FAIL reset_axi: got %b want 00000",
               {bus.arvalid, bus.rready, bus.awvalid, bus.wvalid, bus.bready});
    end
    rst = 1'b1;
  endtask

  task automatic test_nonmem();
    int ar0, aw0, w0;
    ar0 = ar_seen; aw0 = aw_seen; w0 = w_seen;
    run_op("nonmem", 1'b0, 1'b0, F3_LW, 32'h8000_0000, 32'h0, 32'h1234_5678,
           32'h1234_5678, 1'b0, 1'b0, 1, 0);
    checks++;
    if (ar_seen != ar0 || aw_seen != aw0 || w_seen != w0) begin
      errors++; $display("FAIL nonmem_no_bus: got ar/aw/w beats %0d/%0d/%0d want 0/0/0",
                         ar_seen - ar0, aw_seen - aw0, w_seen - w0);
    end
  endtask

  task automatic test_load_byte();
    cfg_rdata = 32'h80FF_FFFF;
    run_op("lb", 1'b1, 1'b0, F3_LB, 32'h8000_0003, 32'h0, 32'h0,
           32'hFFFF_FF80, 1'b0, 1'b0, 3, 0);
    checks++;
    if (last_araddr !== 32'h8000_0003) begin
      errors++; $display("FAIL lb_araddr: got %h want 80000003", last_araddr);
    end
    run_op("lbu", 1'b1, 1'b0, F3_LBU, 32'h8000_0003, 32'h0, 32'h0,
           32'h0000_0080, 1'b0, 1'b0, 3, 0);
  endtask

  task automatic test_store_half();
    aw_wait = 0; w_wait = 2;
    run_op("sh", 1'b0, 1'b1, F3_SH, 32'h8000_0002, 32'h0000_BEEF, 32'h0,
           32'h0, 1'b0, 1'b0, 5, 0);
    w_wait = 0;
    checks++;
    if (last_awaddr !== 32'h8000_0002 || last_wdata !== 32'hBEEF_0000 || last_wstrb !== 4'b1100) begin
      errors++; $display("FAIL sh_lanes: got addr=%h data=%h strb=%b want 80000002 beef0000 1100",
                         last_awaddr, last_wdata, last_wstrb);
    end
  endtask

  task automatic test_store_priority();
    int ar0;
    ar0 = ar_seen;
    cfg_bresp = RESP_DECERR;
    run_op("ren_wen", 1'b1, 1'b1, F3_SW, 32'h8000_000C, 32'h55AA_55AA, 32'h0,
           32'h0, 1'b1, 1'b0, 3, 0);
    cfg_bresp = RESP_OKAY;
    checks++;
    if (ar_seen != ar0 || last_wdata !== 32'h55AA_55AA || last_wstrb !== 4'b1111) begin
      errors++; $display("FAIL ren_wen_store: got ar=%0d data=%h strb=%b want 0 55aa55aa 1111",
                         ar_seen - ar0, last_wdata, last_wstrb);
    end
  endtask

  task automatic test_misalign();
`ifdef LSU_MISALIGN_CHK_EN
    int ar0;
    ar0 = ar_seen;
    cfg_rdata = 32'hFFFF_FFFF;
    run_op("lw_mis", 1'b1, 1'b0, F3_LW, 32'h8000_0001, 32'h0, 32'h0,
           32'h0, 1'b0, 1'b1, 1, 0);
    checks++;
    if (ar_seen != ar0) begin
      errors++; $display("FAIL lw_mis_no_bus: got %0d ar beats want 0", ar_seen - ar0);
    end
`else
    run_op("sh_mis", 1'b0, 1'b1, F3_SH, 32'h8000_0003, 32'h1234_ABCD, 32'h0,
           32'h0, 1'b0, 1'b0, 3, 0);
    checks++;
    if (last_wdata !== 32'hCD00_0000 || last_wstrb !== 4'b1000) begin
      errors++; $display("FAIL sh_mis_lanes: got data=%h strb=%b want cd000000 1000",
                         last_wdata, last_wstrb);
    end
`endif
  endtask

  task automatic test_back_to_back();
    cfg_rdata = 32'h8001_7FFF;
    run_op("lh", 1'b1, 1'b0, F3_LH, 32'h8000_0002, 32'h0, 32'h0,
           32'hFFFF_8001, 1'b0, 1'b0, 3, 0);
    run_op("lhu", 1'b1, 1'b0, F3_LHU, 32'h8000_0002, 32'h0, 32'h0,
           32'h0000_8001, 1'b0, 1'b0, 3, 0);
    run_op("lb0", 1'b1, 1'b0, F3_LB, 32'h8000_0000, 32'h0, 32'h0,
           32'hFFFF_FFFF, 1'b0, 1'b0, 3, 0);
    run_op("sb", 1'b0, 1'b1, F3_SB, 32'h8000_0001, 32'h0000_00AB, 32'h0,
           32'h0, 1'b0, 1'b0, 3, 0);
    checks++;
    if (last_wdata !== 32'h0000_AB00 || last_wstrb !== 4'b0010) begin
      errors++; $display("FAIL sb_lanes: got data=%h strb=%b want 0000ab00 0010",
                         last_wdata, last_wstrb);
    end
    run_op("sw", 1'b0, 1'b1, F3_SW, 32'h8000_0008, 32'h0102_0304, 32'h0,
           32'h0, 1'b0, 1'b0, 3, 0);
    checks++;
    if (last_wdata !== 32'h0102_0304 || last_wstrb !== 4'b1111 || last_awaddr !== 32'h8000_0008) begin
      errors++; $display("FAIL sw_lanes: got addr=%h data=%h strb=%b want 80000008 01020304 1111",
                         last_awaddr, last_wdata, last_wstrb);
    end
  endtask

  task automatic test_load_err();
    r_wait = 3; cfg_rresp = RESP_SLVERR; cfg_rdata = 32'hCAFE_F00D;
    run_op("lw_err", 1'b1, 1'b0, F3_LW, 32'h8000_0010, 32'h0, 32'h0,
           32'hCAFE_F00D, 1'b1, 1'b0, 6, 4);
    r_wait = 0; cfg_rresp = RESP_OKAY;
  endtask

  task automatic test_reset_mid();
    int k;
    r_wait = 20;
    @(negedge clk);
    i_lsu_ren = 1'b1; i_lsu_funct3 = F3_LW; i_lsu_addr = 32'h8000_0004;
    i_pre_valid = 1'b1;
    @(negedge clk);
    i_pre_valid = 1'b0; i_lsu_ren = 1'b0;
    k = 0;
    while (bus.rready !== 1'b1 && k < 10) begin
      @(negedge clk);
      k++;
    end
    checks++;
    if (bus.rready !== 1'b1) begin
      errors++; $display("FAIL rst_mid_reach_r: got rready=%b want 1", bus.rready);
    end
    #1 rst = 1'b0;
    #1;
    checks++;
    if (bus.rready !== 1'b0 || o_post_valid !== 1'b0 || o_lsu_rd !== 32'h0 || o_pre_ready !== 1'b1) begin
      errors++; $display("FAIL rst_mid_outputs: got rready=%b v=%b rd=%h pre=%b want 0 0 0 1",
                         bus.rready, o_post_valid, o_lsu_rd, o_pre_ready);
    end
    @(negedge clk);
    rst = 1'b1;
    r_wait = 0; cfg_rdata = 32'hDEAD_BEEF;
    run_op("lw_after_rst", 1'b1, 1'b0, F3_LW, 32'h8000_0004, 32'h0, 32'h0,
           32'hDEAD_BEEF, 1'b0, 1'b0, 3, 0);
  endtask

  initial begin
    test_reset();
    test_nonmem();
    test_load_byte();
    test_store_half();
    test_store_priority();
    test_misalign();
    test_back_to_back();
    test_load_err();
    test_reset_mid();
    checks++;
    if (sb_q.size() != 0) begin
      errors++; $display("FAIL scoreboard_drain: got %0d left want 0", sb_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
